// File: rtl/ps2_keyboard_sequencer_pkg.sv
// Shared constants and state encoding for the PS/2 keyboard sequencer.
// Imported by the sequencer top and the scancode decoder.
package ps2_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
  localparam logic [7:0] PFX_EXT      = 8'hE0;
  localparam logic [7:0] PFX_BREAK    = 8'hF0;

  typedef enum logic [3:0] {
    INIT_CMD,
    INIT_SENT,
    INIT_ACK,
    INIT_BAT,
    IDLE,
    LED_CMD,
    LED_CMD_SENT,
    LED_CMD_ACK,
    LED_ARG,
    LED_ARG_SENT,
    LED_ARG_ACK
  } state_t;

  function automatic logic is_rsp(logic [7:0] b);
    return (b == RSP_ACK) || (b == RSP_RESEND) ||
           (b == RSP_BAT_OK);
  endfunction

endpackage

// File: rtl/ps2_keyboard_sequencer_if.sv
// Bundle between the sequencer, PS2_Controller and the game logic.
// master = sequencer side, slave = controller/game side.
interface ps2_keyboard_sequencer_if;

  logic [7:0] the_command;
  logic       send_command;
  logic       command_was_sent;
  logic       error_communication_timed_out;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       led_req;
  logic [2:0] led_mask;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_released;
  logic       init_done;
  logic       init_error;
  logic       busy;

  modport master (
    output the_command, send_command,
    output key_valid, key_code,
    output key_extended, key_released,
    output init_done, init_error, busy,
    input  command_was_sent,
    input  error_communication_timed_out,
    input  received_data, received_data_en,
    input  led_req, led_mask
  );

  modport slave (
    input  the_command, send_command,
    input  key_valid, key_code,
    input  key_extended, key_released,
    input  init_done, init_error, busy,
    output command_was_sent,
    output error_communication_timed_out,
    output received_data, received_data_en,
    output led_req, led_mask
  );

endinterface

// File: rtl/ps2_scancode_decoder.sv
// Folds E0/F0 prefixes into single-cycle key events.
// Prefix state is dropped whenever the decoder is disabled.
module ps2_scancode_decoder (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  input  logic       data_en_i,
  output logic       key_valid_o,
  output logic [7:0] key_code_o,
  output logic       key_ext_o,
  output logic       key_rel_o
);
  import ps2_pkg::*;

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       vld_q, vld_d;
  logic [7:0] code_q, code_d;
  logic       kext_q, kext_d;
  logic       krel_q, krel_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      vld_q  <= 1'b0;
      code_q <= '0;
      kext_q <= 1'b0;
      krel_q <= 1'b0;
    end else begin
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      vld_q  <= vld_d;
      code_q <= code_d;
      kext_q <= kext_d;
      krel_q <= krel_d;
    end
  end

  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    vld_d  = 1'b0;
    code_d = code_q;
    kext_d = kext_q;
    krel_d = krel_q;
    if (!en_i) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (data_en_i) begin
      unique case (1'b1)
        (data_i == PFX_EXT):   ext_d = 1'b1;
        (data_i == PFX_BREAK): brk_d = 1'b1;
        is_rsp(data_i):        ;
        default: begin
          vld_d  = 1'b1;
          code_d = data_i;
          kext_d = ext_q;
          krel_d = brk_q;
          ext_d  = 1'b0;
          brk_d  = 1'b0;
        end
      endcase
    end
  end

  assign key_valid_o = vld_q;
  assign key_code_o  = code_q;
  assign key_ext_o   = kext_q;
  assign key_rel_o   = krel_q;

endmodule

// File: rtl/ps2_keyboard_sequencer.sv
// Keyboard init / LED command sequencer with retry and timeout,
// decoding scancodes into key events while idle.
module ps2_keyboard_sequencer #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int RETRY_MAX      = 3
) (
  input  logic CLOCK_50,
  input  logic reset,
  ps2_keyboard_sequencer_if.master bus
);
  import ps2_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RETRY_MAX + 1);

  state_t          state_q, state_d, tgt;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   rty_q, rty_d;
  logic [7:0]      cmd_q, cmd_d;
  logic            send_q, send_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            pend_q, pend_d;
  logic [2:0]      pmask_q, pmask_d;
  logic [2:0]      arg_q, arg_d;
  logic            waiting, led_st, tmo, do_rty;
  logic            rx, rx_ack, rx_rsnd, sent, terr;

  assign rx      = bus.received_data_en;
  assign rx_ack  = rx && (bus.received_data == RSP_ACK);
  assign rx_rsnd = rx && (bus.received_data == RSP_RESEND);
  assign sent    = bus.command_was_sent;
  assign terr    = bus.error_communication_timed_out;

  assign waiting = state_q inside {INIT_SENT, INIT_ACK,
    INIT_BAT, LED_CMD_SENT, LED_CMD_ACK,
    LED_ARG_SENT, LED_ARG_ACK};
  assign led_st = state_q inside {LED_CMD, LED_CMD_SENT,
    LED_CMD_ACK, LED_ARG, LED_ARG_SENT, LED_ARG_ACK};
  assign tmo = waiting &&
    (cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= INIT_CMD;
      cnt_q   <= '0;
      rty_q   <= '0;
      cmd_q   <= '0;
      send_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      pmask_q <= '0;
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rty_q   <= rty_d;
      cmd_q   <= cmd_d;
      send_q  <= send_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      pmask_q <= pmask_d;
      arg_q   <= arg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt     = INIT_CMD;
    rty_d   = rty_q;
    cmd_d   = cmd_q;
    send_d  = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
    pend_d  = pend_q;
    pmask_d = pmask_q;
    arg_d   = arg_q;
    do_rty  = 1'b0;
    if (bus.led_req) begin
      pmask_d = bus.led_mask;
      pend_d  = 1'b1;
    end
    unique case (state_q)
      INIT_CMD: begin
        cmd_d   = CMD_RESET;
        send_d  = 1'b1;
        state_d = INIT_SENT;
      end
      INIT_SENT: begin
        if (sent) state_d = INIT_ACK;
        else if (terr || tmo) do_rty = 1'b1;
      end
      INIT_ACK: begin
        if (rx_ack) begin
          state_d = INIT_BAT;
          rty_d   = '0;
        end else if (rx_rsnd || tmo) do_rty = 1'b1;
      end
      INIT_BAT: begin
        if (rx && bus.received_data == RSP_BAT_OK) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (rx &&
                     bus.received_data == RSP_BAT_FAIL) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (tmo) do_rty = 1'b1;
      end
      IDLE: begin
        // A byte being decoded this cycle defers the LED request.
        if (!rx && (bus.led_req || pend_q)) begin
          state_d = LED_CMD;
          pend_d  = 1'b0;
          arg_d   = bus.led_req ? bus.led_mask : pmask_q;
        end
      end
      LED_CMD: begin
        cmd_d   = CMD_SET_LEDS;
        send_d  = 1'b1;
        state_d = LED_CMD_SENT;
      end
      LED_CMD_SENT: begin
        tgt = LED_CMD;
        if (sent) state_d = LED_CMD_ACK;
        else if (terr || tmo) do_rty = 1'b1;
      end
      LED_CMD_ACK: begin
        tgt = LED_CMD;
        if (rx_ack) begin
          state_d = LED_ARG;
          rty_d   = '0;
        end else if (rx_rsnd || tmo) do_rty = 1'b1;
      end
      LED_ARG: begin
        cmd_d   = {5'b0, arg_q};
        send_d  = 1'b1;
        state_d = LED_ARG_SENT;
      end
      LED_ARG_SENT: begin
        tgt = LED_ARG;
        if (sent) state_d = LED_ARG_ACK;
        else if (terr || tmo) do_rty = 1'b1;
      end
      LED_ARG_ACK: begin
        tgt = LED_ARG;
        if (rx_ack) begin
          state_d = IDLE;
          rty_d   = '0;
        end else if (rx_rsnd || tmo) do_rty = 1'b1;
      end
      default: state_d = INIT_CMD;
    endcase
    if (do_rty) begin
      if (rty_q < RW'(RETRY_MAX)) begin
        rty_d   = rty_q + RW'(1);
        state_d = tgt;
      end else begin
        // Give up: fresh retry budget for the next command.
        err_d   = 1'b1;
        rty_d   = '0;
        state_d = IDLE;
        if (led_st) pend_d = 1'b0;
      end
    end
  end

  assign cnt_d = (waiting && state_d == state_q) ?
                 cnt_q + TW'(1) : '0;

  ps2_scancode_decoder u_dec (
    .clk_i       (CLOCK_50),
    .rst_i       (reset),
    .en_i        (state_q == IDLE),
    .data_i      (bus.received_data),
    .data_en_i   (bus.received_data_en),
    .key_valid_o (bus.key_valid),
    .key_code_o  (bus.key_code),
    .key_ext_o   (bus.key_extended),
    .key_rel_o   (bus.key_released)
  );

  assign bus.the_command  = cmd_q;
  assign bus.send_command = send_q;
  assign bus.init_done    = done_q;
  assign bus.init_error   = err_q;
  assign bus.busy         = (state_q != IDLE);

endmodule
